// File: rtl/mtsp_mem_burst_issuer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mtsp_mem_burst_issuer_pkg : shared constants, FSM states, burst-length helper
// Rev 1.0
// ---------------------------------------------------------------------------
package mtsp_mem_burst_issuer_pkg;

  localparam int DEF_ADDR_W          = 32;
  localparam int DEF_GADDR_W         = 12;
  localparam int DEF_SIZE_W          = 8;
  localparam int DEF_MAX_BURST       = 16;
  localparam int DEF_MAX_OUTSTANDING = 4;

  localparam int BOUNDARY_4K = 4096;
  localparam int BEAT_BYTES  = 16;
  localparam logic [8:0] BOUNDARY_BEATS = 9'(BOUNDARY_4K / BEAT_BYTES);
  localparam int LEN_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Beats in the next burst: limited by what is left, the burst cap and the 4 KB page end.
  function automatic logic [LEN_W-1:0] burst_len(input logic [31:0] rem,
                                                 input logic [7:0]  page_idx,
                                                 input int          max_burst);
    logic [8:0] bnd;
    logic [8:0] len;
    bnd = BOUNDARY_BEATS - {1'b0, page_idx};
    len = (bnd < 9'(max_burst)) ? bnd : 9'(max_burst);
    if (rem < {23'd0, len}) len = rem[8:0];
    return len[LEN_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mtsp_mem_burst_issuer_len_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mtsp_burst_len_fifo : small FIFO of issued burst lengths for beat tracking
// Rev 1.0
// ---------------------------------------------------------------------------
module mtsp_burst_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mtsp_mem_burst_issuer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mtsp_mem_burst_issuer : splits a transfer descriptor into 4 KB-safe bus bursts
// Rev 1.0
// ---------------------------------------------------------------------------
module mtsp_mem_burst_issuer
  import mtsp_mem_burst_issuer_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int GADDR_W         = DEF_GADDR_W,
  parameter int SIZE_W          = DEF_SIZE_W,
  parameter int MAX_BURST       = DEF_MAX_BURST,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               DESC_REQ,
  input  logic               DESC_WE,
  input  logic [ADDR_W-1:0]  DESC_PADDR,
  input  logic [GADDR_W-1:0] DESC_GADDR,
  input  logic [SIZE_W-1:0]  DESC_SIZE,
  output logic               MEM_BUSY,
  output logic               DONE,
  output logic               BUS_AREQ,
  input  logic               BUS_AACK,
  output logic               BUS_AWE,
  output logic [ADDR_W-1:0]  BUS_ADDR,
  output logic [3:0]         BUS_ALEN,
  input  logic               BUS_BEAT,
  output logic               GMEM_EN,
  output logic               GMEM_WE,
  output logic [GADDR_W-1:0] GMEM_ADDR
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  state_t             state;
  logic [SIZE_W-1:0]  remaining_req;
  logic [SIZE_W-1:0]  remaining_beats;
  logic [LEN_W-1:0]   cur_len;
  logic [LEN_W-1:0]   beat_cnt;
  logic [GADDR_W-1:0] gptr;
  logic [OUT_W-1:0]   outstanding;
  logic [OUT_W-1:0]   outstanding_n;

  logic               desc_load;
  logic               issue_fire;
  logic               beat_fire;
  logic               burst_done;
  logic               areq_n;
  logic [LEN_W-1:0]   fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ADDR_W-1:0]  desc_addr;
  logic [ADDR_W-1:0]  next_addr;
  logic [SIZE_W-1:0]  next_rem;
  logic [SIZE_W-1:0]  beats_left_n;
  logic [LEN_W-1:0]   desc_len;
  logic [LEN_W-1:0]   next_len;
  logic [3:0]         unused_paddr_lsb;

  assign unused_paddr_lsb = DESC_PADDR[3:0];

  assign desc_load  = (state == ST_IDLE) & DESC_REQ & (DESC_SIZE != '0);
  assign issue_fire = BUS_AREQ & BUS_AACK;
  assign beat_fire  = BUS_BEAT & MEM_BUSY;
  // The head of the length FIFO is always the oldest burst still receiving beats.
  assign burst_done = beat_fire & ~fifo_empty & ((beat_cnt + LEN_W'(1)) == fifo_head);

  assign outstanding_n = outstanding + OUT_W'(issue_fire) - OUT_W'(burst_done);
  assign areq_n        = (outstanding_n < OUT_W'(MAX_OUTSTANDING));

  assign desc_addr    = {DESC_PADDR[ADDR_W-1:4], 4'b0000};
  assign desc_len     = burst_len(32'(DESC_SIZE), DESC_PADDR[11:4], MAX_BURST);
  assign next_addr    = BUS_ADDR + ADDR_W'({cur_len, 4'b0000});
  assign next_rem     = remaining_req - SIZE_W'(cur_len);
  assign next_len     = burst_len(32'(next_rem), next_addr[11:4], MAX_BURST);
  assign beats_left_n = remaining_beats - SIZE_W'(beat_fire);

  assign GMEM_EN   = beat_fire;
  assign GMEM_WE   = ~BUS_AWE;
  assign GMEM_ADDR = gptr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= ST_IDLE;
      MEM_BUSY      <= 1'b0;
      DONE          <= 1'b0;
      BUS_AREQ      <= 1'b0;
      BUS_AWE       <= 1'b0;
      BUS_ADDR      <= '0;
      BUS_ALEN      <= '0;
      remaining_req <= '0;
      cur_len       <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (DESC_REQ) begin
            if (DESC_SIZE == '0) begin
              DONE <= 1'b1;
            end else begin
              state         <= ST_ISSUE;
              MEM_BUSY      <= 1'b1;
              BUS_AREQ      <= 1'b1;
              BUS_AWE       <= DESC_WE;
              BUS_ADDR      <= desc_addr;
              BUS_ALEN      <= 4'(desc_len - LEN_W'(1));
              cur_len       <= desc_len;
              remaining_req <= DESC_SIZE;
            end
          end
        end
        ST_ISSUE: begin
          BUS_AREQ <= areq_n;
          if (issue_fire) begin
            BUS_ADDR      <= next_addr;
            remaining_req <= next_rem;
            if (next_rem == '0) begin
              state    <= ST_DRAIN;
              BUS_AREQ <= 1'b0;
            end else begin
              cur_len  <= next_len;
              BUS_ALEN <= 4'(next_len - LEN_W'(1));
            end
          end
        end
        ST_DRAIN: begin
          // A last beat arriving this cycle already counts toward completion.
          if (beats_left_n == '0) begin
            DONE     <= 1'b1;
            MEM_BUSY <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      remaining_beats <= '0;
      gptr            <= '0;
      outstanding     <= '0;
      beat_cnt        <= '0;
    end else begin
      outstanding <= outstanding_n;
      if (desc_load) begin
        remaining_beats <= DESC_SIZE;
        gptr            <= DESC_GADDR;
      end else if (beat_fire) begin
        remaining_beats <= beats_left_n;
        gptr            <= gptr + GADDR_W'(1);
      end
      if (burst_done)
        beat_cnt <= '0;
      else if (beat_fire & ~fifo_empty)
        beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

  mtsp_burst_len_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (LEN_W)
  ) u_len_fifo (
    .clk       (CLK),
    .rst_n     (nRST),
    .push      (issue_fire & ~fifo_full),
    .push_data (cur_len),
    .pop       (burst_done),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_mtsp_mem_burst_issuer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mtsp_mem_burst_issuer : directed + randomized bench with a burst/beat model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mtsp_mem_burst_issuer;

  localparam int MAX_BURST = 16;
  localparam int MAX_OUT   = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        DESC_REQ, DESC_WE;
  logic [31:0] DESC_PADDR;
  logic [11:0] DESC_GADDR;
  logic [7:0]  DESC_SIZE;
  logic        MEM_BUSY, DONE, BUS_AREQ, BUS_AACK, BUS_AWE, BUS_BEAT;
  logic [31:0] BUS_ADDR;
  logic [3:0]  BUS_ALEN;
  logic        GMEM_EN, GMEM_WE;
  logic [11:0] GMEM_ADDR;

  always #5 CLK = ~CLK;

  mtsp_mem_burst_issuer dut (
    .CLK(CLK), .nRST(nRST),
    .DESC_REQ(DESC_REQ), .DESC_WE(DESC_WE), .DESC_PADDR(DESC_PADDR),
    .DESC_GADDR(DESC_GADDR), .DESC_SIZE(DESC_SIZE),
    .MEM_BUSY(MEM_BUSY), .DONE(DONE),
    .BUS_AREQ(BUS_AREQ), .BUS_AACK(BUS_AACK), .BUS_AWE(BUS_AWE),
    .BUS_ADDR(BUS_ADDR), .BUS_ALEN(BUS_ALEN), .BUS_BEAT(BUS_BEAT),
    .GMEM_EN(GMEM_EN), .GMEM_WE(GMEM_WE), .GMEM_ADDR(GMEM_ADDR)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  alen;
  } burst_t;

  burst_t      exp_q[$];      // bursts still to be requested, in order
  int          bursts_out[$]; // beats still owed by each accepted burst
  int          checks = 0;
  int          failures = 0;
  int          dut_hs = 0;
  logic        busy_exp = 1'b0;
  logic        done_exp = 1'b0;
  logic        we_exp = 1'b0;
  logic [11:0] gexp = '0;
  int          beats_left = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void plan(input logic [31:0] paddr, input int size);
    logic [31:0] a;
    int          rem, l, bnd;
    burst_t      b;
    exp_q.delete();
    a   = paddr & 32'hFFFF_FFF0;
    rem = size;
    while (rem > 0) begin
      bnd = 256 - int'(a[11:4]);
      l   = rem;
      if (l > MAX_BURST) l = MAX_BURST;
      if (l > bnd) l = bnd;
      b.addr = a;
      b.alen = 4'(l - 1);
      exp_q.push_back(b);
      a   = a + 32'(l * 16);
      rem = rem - l;
    end
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit aack, input bit beat, input bit req);
    bit areq_exp, bf, hs, dnext, bnext;
    BUS_AACK = aack;
    BUS_BEAT = beat && (bursts_out.size() > 0);
    DESC_REQ = req;
    #2;
    areq_exp = busy_exp && (exp_q.size() > 0) && (bursts_out.size() < MAX_OUT);
    check("mem_busy", 32'(MEM_BUSY), 32'(busy_exp));
    check("done", 32'(DONE), 32'(done_exp));
    check("bus_areq", 32'(BUS_AREQ), 32'(areq_exp));
    if (areq_exp) begin
      check("bus_addr", BUS_ADDR, exp_q[0].addr);
      check("bus_alen", 32'(BUS_ALEN), 32'(exp_q[0].alen));
      check("bus_awe", 32'(BUS_AWE), 32'(we_exp));
    end
    bf = BUS_BEAT && busy_exp;
    check("gmem_en", 32'(GMEM_EN), 32'(bf));
    if (bf) begin
      check("gmem_addr", 32'(GMEM_ADDR), 32'(gexp));
      check("gmem_we", 32'(GMEM_WE), 32'(!we_exp));
    end
    if (BUS_AREQ && BUS_AACK) dut_hs++;
    hs    = areq_exp && aack;
    dnext = 1'b0;
    bnext = busy_exp;
    if (bf) begin
      gexp = gexp + 12'd1;
      beats_left--;
      bursts_out[0] = bursts_out[0] - 1;
      if (bursts_out[0] == 0) void'(bursts_out.pop_front());
      if (beats_left == 0) begin
        bnext = 1'b0;
        dnext = 1'b1;
      end
    end
    if (hs) begin
      bursts_out.push_back(int'(exp_q[0].alen) + 1);
      void'(exp_q.pop_front());
    end
    if (req && !busy_exp) begin
      if (DESC_SIZE == 8'd0) dnext = 1'b1;
      else begin
        bnext      = 1'b1;
        plan(DESC_PADDR, int'(DESC_SIZE));
        beats_left = int'(DESC_SIZE);
        gexp       = DESC_GADDR;
        we_exp     = DESC_WE;
      end
    end
    busy_exp = bnext;
    done_exp = dnext;
    @(posedge CLK);
    #1;
    DESC_REQ = 1'b0;
  endtask

  task automatic set_desc(input logic [31:0] pa, input logic [11:0] ga,
                          input logic [7:0] sz, input bit we);
    DESC_PADDR = pa;
    DESC_GADDR = ga;
    DESC_SIZE  = sz;
    DESC_WE    = we;
  endtask

  task automatic run(input int aack_pct, input int beat_pct);
    int n = 0;
    while (busy_exp && n < 3000) begin
      step($urandom_range(99) < aack_pct, $urandom_range(99) < beat_pct, 1'b0);
      n++;
    end
    check("drain_bound", 32'(n < 3000), 32'(1));
  endtask

  initial begin
    nRST = 1'b0;
    DESC_REQ = 1'b0; BUS_AACK = 1'b0; BUS_BEAT = 1'b0;
    set_desc(32'h0, 12'h0, 8'd0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", 32'(MEM_BUSY), 32'(0));
    check("rst_done", 32'(DONE), 32'(0));
    check("rst_areq", 32'(BUS_AREQ), 32'(0));
    check("rst_awe", 32'(BUS_AWE), 32'(0));
    check("rst_addr", BUS_ADDR, 32'(0));
    check("rst_alen", 32'(BUS_ALEN), 32'(0));
    nRST = 1'b1;
    step(0, 0, 0);

    // Single aligned burst, read direction.
    dut_hs = 0;
    set_desc(32'h0000_1000, 12'h000, 8'd16, 1'b0);
    step(1, 1, 1);
    run(100, 100);
    check("t1_bursts", 32'(dut_hs), 32'(1));

    // Page-end split, issued in the DONE cycle of the previous transfer.
    dut_hs = 0;
    set_desc(32'h0000_1FC0, 12'h020, 8'd10, 1'b1);
    step(1, 1, 1);
    run(100, 100);
    check("t2_bursts", 32'(dut_hs), 32'(2));

    // Outstanding limit with no beats returned, then one burst completes.
    dut_hs = 0;
    set_desc(32'h0000_1000, 12'hFF8, 8'd80, 1'b0);
    step(1, 0, 1);
    repeat (10) step(1, 0, 0);
    check("t3_limit", 32'(dut_hs), 32'(4));
    repeat (16) step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("t3_fifth", 32'(dut_hs), 32'(5));
    run(60, 70);

    // Request held without acknowledge.
    dut_hs = 0;
    set_desc(32'h0000_2F80, 12'h100, 8'd40, 1'b1);
    step(0, 0, 1);
    repeat (5) step(0, 0, 0);
    check("t4_no_hs", 32'(dut_hs), 32'(0));
    run(50, 50);

    // Issue and burst completion in the same cycle.
    set_desc(32'h0000_3000, 12'h200, 8'd80, 1'b0);
    step(1, 0, 1);
    repeat (3) step(1, 0, 0);
    repeat (15) step(0, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    run(80, 80);

    // Empty descriptor, followed by a request in its DONE cycle.
    dut_hs = 0;
    set_desc(32'h0000_5000, 12'h000, 8'd0, 1'b0);
    step(1, 0, 1);
    set_desc(32'h0000_5000, 12'h300, 8'd5, 1'b1);
    step(1, 1, 1);
    run(100, 100);
    check("t6_bursts", 32'(dut_hs), 32'(1));

    // Reset in the middle of a transfer.
    dut_hs = 0;
    set_desc(32'h0000_4000, 12'h010, 8'd64, 1'b1);
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    check("t7_two_issued", 32'(dut_hs), 32'(2));
    BUS_AACK = 1'b0;
    BUS_BEAT = 1'b1;
    #1;
    nRST = 1'b0;
    #1;
    check("arst_busy", 32'(MEM_BUSY), 32'(0));
    check("arst_done", 32'(DONE), 32'(0));
    check("arst_areq", 32'(BUS_AREQ), 32'(0));
    check("arst_awe", 32'(BUS_AWE), 32'(0));
    check("arst_addr", BUS_ADDR, 32'(0));
    check("arst_alen", 32'(BUS_ALEN), 32'(0));
    check("arst_gmem_en", 32'(GMEM_EN), 32'(0));
    BUS_BEAT = 1'b0;
    @(posedge CLK);
    #1;
    check("arst_no_done", 32'(DONE), 32'(0));
    nRST = 1'b1;
    exp_q.delete();
    bursts_out.delete();
    busy_exp = 1'b0;
    done_exp = 1'b0;
    beats_left = 0;
    step(0, 0, 0);
    set_desc(32'h0000_6FE0, 12'hFFE, 8'd20, 1'b0);
    step(1, 0, 1);
    run(70, 70);

    // Randomized descriptors, some near page ends and GMB wrap.
    for (int i = 0; i < 10; i++) begin
      DESC_PADDR = $urandom();
      if ($urandom_range(1) == 1) DESC_PADDR[11:4] = 8'hF0 | 8'($urandom_range(15));
      DESC_GADDR = 12'($urandom());
      DESC_SIZE  = 8'($urandom_range(80));
      DESC_WE    = 1'($urandom_range(1));
      step($urandom_range(1) == 1, 1'b0, 1'b1);
      run($urandom_range(30, 100), $urandom_range(30, 100));
    end
    step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
